subcode_q_decoder: RTL

SUBCODE_Q_DECODER -- requirements
Module: subcode_q_decoder

---
 rtl/subcode_pkg.sv | 14 +
 rtl/crc16_serial.sv | 39 +++
 rtl/subcode_q_decoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/subcode_pkg.sv
// Shared constants and FSM state type for the CD subcode Q-channel decoder.
package subcode_pkg;

  localparam int          Q_BITS      = 96;
  localparam int          Q_DATA_BITS = 80;
  localparam logic [15:0] Q_CRC_POLY  = 16'h1021;

  typedef enum logic [1:0] {
    IDLE,
    GOT_S0,
    COLLECT
  } qdec_state_e;

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16 (polynomial Q_CRC_POLY, init zero), one bit per enabled cycle.
module crc16_serial
  import subcode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        feedback;

  // Next CRC value: clear wins over a new bit, otherwise shift and conditionally fold in the polynomial
  always_comb begin
    feedback = crc_q[15] ^ bit_in;
    crc_d    = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (bit_en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (feedback ? Q_CRC_POLY : 16'h0000);
    end
  end

  // CRC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/subcode_q_decoder.sv
// Subcode Q-channel decoder: syncs on S0/S1, collects 96 Q bits, checks the CRC.
// Optional feature: define QDEC_ERR_CNT_EN to add the saturating ERR_CNT output.
module subcode_q_decoder
  import subcode_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic        SCK,
  input  logic        RST_N,
  input  logic        FRAME_VALID,
  input  logic [7:0]  SUBCODE,
  input  logic        S0,
  input  logic        S1,
  output logic [79:0] Q_DATA,
  output logic [3:0]  Q_CONTROL,
  output logic [3:0]  Q_ADR,
  output logic        Q_VALID,
  output logic        CRC_OK,
  output logic        LOCKED
`ifdef QDEC_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0] ERR_CNT
`endif
);

  qdec_state_e        state_q, state_d;
  logic               fv_q;
  logic [6:0]         cnt_q;
  logic [Q_BITS-1:0]  shift_q;
  logic [79:0]        qdata_q;
  logic               qvalid_q;
  logic               crcok_q;
  logic [15:0]        crcVal;

  logic               accept;
  logic               startBlock;
  logic               dataBit;
  logic               lastBit;
  logic               syncLoss;
  logic               crcBitEn;
  logic               crcGood;
  logic [Q_BITS-1:0]  fullWord;
  logic               unusedBits;

  // A frame counts once, on the rising edge of FRAME_VALID
  assign accept   = FRAME_VALID & ~fv_q;
  assign fullWord = {shift_q[Q_BITS-2:0], SUBCODE[6]};
  assign crcBitEn = dataBit && (cnt_q < 7'(Q_DATA_BITS));
  assign crcGood  = (fullWord[15:0] == ~crcVal);
  assign unusedBits = ^{SUBCODE[7], SUBCODE[5:0], shift_q[Q_BITS-1]};

  // Sync search and collection control; abort priority is S0 (resync) before S1 (drop to IDLE)
  always_comb begin
    state_d    = state_q;
    startBlock = 1'b0;
    dataBit    = 1'b0;
    lastBit    = 1'b0;
    syncLoss   = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (S0) state_d = GOT_S0;
        end
        GOT_S0: begin
          if (S1) begin
            state_d    = COLLECT;
            startBlock = 1'b1;
          end else if (!S0) begin
            state_d = IDLE;
          end
        end
        COLLECT: begin
          if (S0) begin
            state_d  = GOT_S0;
            syncLoss = 1'b1;
          end else if (S1) begin
            state_d  = IDLE;
            syncLoss = 1'b1;
          end else begin
            dataBit = 1'b1;
            if (cnt_q == 7'(Q_BITS - 1)) begin
              lastBit = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, edge detect, bit collection and the registered block result
  always_ff @(posedge SCK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      fv_q     <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
      qdata_q  <= '0;
      qvalid_q <= 1'b0;
      crcok_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fv_q     <= FRAME_VALID;
      qvalid_q <= lastBit;
      if (startBlock) begin
        cnt_q   <= '0;
        shift_q <= '0;
      end
      if (dataBit) begin
        shift_q <= fullWord;
        cnt_q   <= lastBit ? 7'd0 : cnt_q + 7'd1;
      end
      if (lastBit) begin
        qdata_q <= fullWord[Q_BITS-1 -: Q_DATA_BITS];
        crcok_q <= crcGood;
      end
    end
  end

  crc16_serial u_crc (
    .clk    (SCK),
    .rst_n  (RST_N),
    .clear  (startBlock),
    .bit_en (crcBitEn),
    .bit_in (SUBCODE[6]),
    .crc    (crcVal)
  );

`ifdef QDEC_ERR_CNT_EN
  logic [ERR_W-1:0] errCnt_q;

  // Saturating count of CRC failures and sync-loss aborts
  always_ff @(posedge SCK or negedge RST_N) begin
    if (!RST_N) begin
      errCnt_q <= '0;
    end else if ((syncLoss || (lastBit && !crcGood)) && (errCnt_q != '1)) begin
      errCnt_q <= errCnt_q + 1'b1;
    end
  end

  assign ERR_CNT = errCnt_q;
`else
  logic unusedSyncLoss;
  assign unusedSyncLoss = syncLoss;
`endif

  assign Q_DATA    = qdata_q;
  assign Q_CONTROL = qdata_q[79:76];
  assign Q_ADR     = qdata_q[75:72];
  assign Q_VALID   = qvalid_q;
  assign CRC_OK    = crcok_q;
  assign LOCKED    = (state_q == COLLECT);

endmodule
